// File: rtl/output_sequencer.sv
// -----------------------------------------------------------------------------
// output_sequencer
// Frame-level controller for the histogram-equalisation output pipeline.
// Accepts a CDF-ready request, latches CdfMin, computes the divisor
// (PIXEL_COUNT - CdfMin), fires the pipeline start pulse, waits for done plus
// a fixed drain, then flips the output bank so the next frame writes the
// other bank. Flags an out-of-range CdfMin and a hung pipeline (timeout).
//
//  state  | meaning
//  IDLE   | waiting for req
//  CALC   | request acked, CdfMin range check
//  LAUNCH | start pulse, RUN timer cleared
//  RUN    | waiting for done, timeout counter running
//  DRAIN  | DRAIN_CYCLES cycles for the last stores to land
//  FINISH | frame_done pulse, bank flip and frame count on exit
//  ERROR  | sticky err until clear_err
//
// Ports
//  clock, reset          system clock, synchronous active-high reset
//  req, req_cdf_min      frame request and its CdfMin
//  req_ack               1-cycle accept pulse
//  clear_err             leaves ERROR
//  start                 1-cycle pipeline start pulse
//  CdfMin, divisor       latched CdfMin and PIXEL_COUNT - CdfMin
//  output_base_offset    bank select used by the pipeline
//  done                  pipeline completion input (only honoured in RUN)
//  busy                  high in CALC..FINISH
//  frame_done            1-cycle pulse when a frame is fully stored
//  ready_bank            bank of the most recently completed frame
//  frame_count           completed frames, wraps at 256
//  err                   high while in ERROR
// -----------------------------------------------------------------------------
module output_sequencer #(
  parameter int PIXEL_COUNT  = 65536,
  parameter int DRAIN_CYCLES = 4,
  parameter int TIMEOUT      = 70000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [19:0] req_cdf_min,
  output logic        req_ack,
  input  logic        clear_err,
  output logic        start,
  output logic [19:0] CdfMin,
  output logic [19:0] divisor,
  output logic        output_base_offset,
  input  logic        done,
  output logic        busy,
  output logic        frame_done,
  output logic        ready_bank,
  output logic [7:0]  frame_count,
  output logic        err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [19:0] PIX = 20'(PIXEL_COUNT);

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_LAUNCH, S_RUN, S_DRAIN, S_FINISH, S_ERROR
  } state_t;

  state_t        state;
  logic [TW-1:0] run_timer;
  logic [DW-1:0] drain_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state              <= S_IDLE;
      run_timer          <= '0;
      drain_cnt          <= '0;
      req_ack            <= 1'b0;
      start              <= 1'b0;
      CdfMin             <= '0;
      divisor            <= '0;
      output_base_offset <= 1'b0;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      ready_bank         <= 1'b0;
      frame_count        <= '0;
      err                <= 1'b0;
    end else begin
      req_ack    <= 1'b0;
      start      <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            // Divisor is computed at accept so it is already valid in CALC;
            // an out-of-range CdfMin forces it to zero.
            CdfMin  <= req_cdf_min;
            divisor <= (req_cdf_min >= PIX) ? 20'd0 : PIX - req_cdf_min;
            req_ack <= 1'b1;
            busy    <= 1'b1;
            state   <= S_CALC;
          end
        end
        S_CALC: begin
          if (CdfMin >= PIX) begin
            busy  <= 1'b0;
            err   <= 1'b1;
            state <= S_ERROR;
          end else begin
            start <= 1'b1;
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          run_timer <= '0;
          state     <= S_RUN;
        end
        S_RUN: begin
          // done takes priority over a timeout in the same cycle
          if (done) begin
            drain_cnt <= DW'(DRAIN_CYCLES - 1);
            state     <= S_DRAIN;
          end else if (run_timer == TW'(TIMEOUT - 1)) begin
            busy  <= 1'b0;
            err   <= 1'b1;
            state <= S_ERROR;
          end else begin
            run_timer <= run_timer + TW'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == '0) begin
            frame_done <= 1'b1;
            state      <= S_FINISH;
          end else begin
            drain_cnt <= drain_cnt - DW'(1);
          end
        end
        S_FINISH: begin
          ready_bank         <= output_base_offset;
          output_base_offset <= ~output_base_offset;
          frame_count        <= frame_count + 8'd1;
          busy               <= 1'b0;
          state              <= S_IDLE;
        end
        S_ERROR: begin
          if (clear_err) begin
            err   <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
